// File: rtl/mult_bist_pkg.sv
// Shared types and width helpers for the multiplier self-test controller.
package mult_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // One extra bit so a fully correct sweep of 2^(2W) vectors is representable.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/mult_bist_if.sv
// Operand/product bus between the self-test controller and the multiplier under test.
interface mult_bist_if
    import mult_bist_pkg::*;
#(
    parameter int W = 4
);
    logic [W-1:0]         a_o;
    logic [W-1:0]         b_o;
    logic [prod_w(W)-1:0] y_i;

    modport master (output a_o, b_o, input y_i);
    modport slave  (input a_o, b_o, output y_i);
endinterface

// File: rtl/mult_bist_exp_pipe.sv
// Delays the exact product and its valid flag by LAT cycles to line up with y_i.
module mult_bist_exp_pipe #(
    parameter int PW  = 8,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [PW-1:0] in_exp,
    output logic          out_vld,
    output logic [PW-1:0] out_exp
);
    generate
        if (LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_vld        = in_vld;
            assign out_exp        = in_exp;
        end else begin : g_pipe
            logic [LAT:1]         vld_pipe;
            logic [LAT:1][PW-1:0] exp_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    exp_pipe <= '0;
                end else begin
                    vld_pipe[1] <= in_vld;
                    exp_pipe[1] <= in_exp;
                    for (int i = 2; i <= LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        exp_pipe[i] <= exp_pipe[i-1];
                    end
                end
            end

            assign out_vld = vld_pipe[LAT];
            assign out_exp = exp_pipe[LAT];
        end
    endgenerate
endmodule

// File: rtl/mult_bist_ctrl.sv
// Exhaustive sweep of all operand pairs into a multiplier, accumulating
// exact-match count, summed absolute error and worst-case error.
module mult_bist_ctrl
    import mult_bist_pkg::*;
#(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    mult_bist_if.master           bus,
    output logic                  busy,
    output logic                  done,
    output logic [cnt_w(W)-1:0]   correct_cnt,
    output logic [sum_w(W)-1:0]   err_sum,
    output logic [prod_w(W)-1:0]  max_err
);
    localparam int PW  = prod_w(W);
    localparam int CW  = cnt_w(W);
    localparam int SW  = sum_w(W);
    localparam int DCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PW-1:0]  LAST_IDX   = '1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((LAT > 0) ? LAT - 1 : 0);

    bist_state_e    state_q, state_d;
    logic [PW-1:0]  idx_q;
    logic [DCW-1:0] drain_q;
    logic           check_en, chk_vld;
    logic [PW-1:0]  exp_in, exp_out, diff;
    logic [PW:0]    delta;

    // idx is the operand register itself: A is the upper half, B the lower.
    assign bus.a_o = idx_q[PW-1:W];
    assign bus.b_o = idx_q[W-1:0];
    assign exp_in  = PW'(bus.a_o) * PW'(bus.b_o);

    mult_bist_exp_pipe #(.PW(PW), .LAT(LAT)) u_exp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (state_q == RUN),
        .in_exp  (exp_in),
        .out_vld (chk_vld),
        .out_exp (exp_out)
    );

    // Difference taken one bit wider so the sign survives, then folded to |diff|.
    assign delta = {1'b0, bus.y_i} - {1'b0, exp_out};
    assign diff  = delta[PW] ? PW'(-delta) : delta[PW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        check_en = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy     = 1'b1;
                check_en = chk_vld;
                if (idx_q == LAST_IDX) state_d = (LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                check_en = chk_vld;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            drain_q     <= '0;
            correct_cnt <= '0;
            err_sum     <= '0;
            max_err     <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                idx_q       <= '0;
                correct_cnt <= '0;
                err_sum     <= '0;
                max_err     <= '0;
            end else if (state_q == RUN && idx_q != LAST_IDX) begin
                idx_q <= idx_q + PW'(1);
            end

            drain_q <= (state_q == DRAIN) ? drain_q + DCW'(1) : '0;

            if (check_en) begin
                if (diff == '0) correct_cnt <= correct_cnt + CW'(1);
                err_sum <= err_sum + SW'(diff);
                if (diff > max_err) max_err <= diff;
            end
        end
    end
endmodule

// File: tb/tb_mult_bist_ctrl.sv
// Self-checking bench: a combinational (LAT=0) and a registered (LAT=2) model
// multiplier swept in parallel, checked against constants and a reference model.
module tb_mult_bist_ctrl;

    logic       clk, rst_n, start;
    logic       busy0, done0, busy2, done2;
    logic [8:0] cnt0, cnt2;
    logic [15:0] sum0, sum2;
    logic [7:0] max0, max2;

    int         mode;
    logic [7:0] yrand [256];
    logic [7:0] s1, s2;

    int checks, errors;
    int d0c, d2c, np0, np2;
    bit seq_ok;

    typedef struct {
        string name;
        int    mode;
        bit    repulse;
        int    exp_cnt;
        int    exp_sum;
        int    exp_max;
    } vec_t;
    vec_t tbl [4];

    mult_bist_if #(.W(4)) bus0 ();
    mult_bist_if #(.W(4)) bus2 ();

    mult_bist_ctrl #(.W(4), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .correct_cnt(cnt0), .err_sum(sum0), .max_err(max0)
    );

    mult_bist_ctrl #(.W(4), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .correct_cnt(cnt2), .err_sum(sum2), .max_err(max2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier behaviour under test: 0 exact, 1 stuck-at-zero, 2 exact but 3*3=7, 3 random table.
    function automatic logic [7:0] ymodel(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        case (mode)
            1:       return 8'd0;
            2:       return (a == 4'd3 && b == 4'd3) ? 8'd7 : p;
            3:       return yrand[{a, b}];
            default: return p;
        endcase
    endfunction

    always_comb bus0.y_i = ymodel(bus0.a_o, bus0.b_o);

    always_ff @(posedge clk) begin
        s1 <= ymodel(bus2.a_o, bus2.b_o);
        s2 <= s1;
    end
    assign bus2.y_i = s2;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Accuracy figures straight from the definition, over every operand pair.
    task automatic model(output int c, output int s, output int m);
        c = 0; s = 0; m = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int y, e, d;
                y = int'(ymodel(4'(ia), 4'(ib)));
                e = ia * ib;
                d = (y > e) ? y - e : e - y;
                if (d == 0) c++;
                s += d;
                if (d > m) m = d;
            end
        end
    endtask

    // c counts cycles after the edge that sampled start; sampled on the falling edge.
    task automatic sweep(input bit repulse);
        d0c = -1; d2c = -1; np0 = 0; np2 = 0; seq_ok = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c < 256 && {bus0.a_o, bus0.b_o} != 8'(c)) seq_ok = 1'b0;
            if (c >= 256 && {bus0.a_o, bus0.b_o} != 8'd255) seq_ok = 1'b0;
            if (busy0 != (c < 256)) seq_ok = 1'b0;
            if (busy2 != (c < 258)) seq_ok = 1'b0;
            if (done0) begin np0++; if (d0c < 0) d0c = c; end
            if (done2) begin np2++; if (d2c < 0) d2c = c; end
            start = repulse && (c == 10 || c == 200);
            if (c >= 262) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int ec, input int es, input int em);
        chk({tag, "_cnt0"}, cnt0, ec);
        chk({tag, "_sum0"}, sum0, es);
        chk({tag, "_max0"}, max0, em);
        chk({tag, "_cnt2"}, cnt2, ec);
        chk({tag, "_sum2"}, sum2, es);
        chk({tag, "_max2"}, max2, em);
        chk({tag, "_done_cyc0"}, d0c, 256);
        chk({tag, "_done_cyc2"}, d2c, 258);
        chk({tag, "_done_pulses0"}, np0, 1);
        chk({tag, "_done_pulses2"}, np2, 1);
        chk({tag, "_seq_busy"}, seq_ok, 1);
    endtask

    initial begin
        int ec, es, em;
        checks = 0; errors = 0;
        mode = 0; start = 1'b0; rst_n = 1'b0;
        foreach (yrand[i]) yrand[i] = 8'd0;

        tbl[0] = '{"exact",   0, 1'b0, 256, 0,     0};
        tbl[1] = '{"stuck0",  1, 1'b0, 31,  14400, 225};
        tbl[2] = '{"glitch33", 2, 1'b0, 255, 2,    2};
        tbl[3] = '{"repulse", 0, 1'b1, 256, 0,     0};

        #12;
        chk("rst_ab0",   {bus0.a_o, bus0.b_o}, 0);
        chk("rst_flags0", {busy0, done0}, 0);
        chk("rst_metrics0", {cnt0, sum0, max0}, 0);
        chk("rst_all2", {bus2.a_o, bus2.b_o, busy2, done2, cnt2, sum2, max2}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[t]) begin
            mode = tbl[t].mode;
            sweep(tbl[t].repulse);
            check_run(tbl[t].name, tbl[t].exp_cnt, tbl[t].exp_sum, tbl[t].exp_max);
            repeat (2) @(negedge clk);
        end

        // Metrics must hold while idle.
        chk("hold_cnt0", cnt0, 256);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++)
                yrand[i] = ($urandom_range(0, 1) == 1) ? 8'((i >> 4) * (i & 15))
                                                      : 8'($urandom_range(0, 255));
            mode = 3;
            model(ec, es, em);
            sweep(1'b0);
            check_run($sformatf("rand%0d", r), ec, es, em);
            repeat (2) @(negedge clk);
        end

        // Abort a sweep at vector 100 and check a fresh one afterwards.
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_vec", {bus0.a_o, bus0.b_o}, 100);
        chk("mid_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out0", {bus0.a_o, bus0.b_o, busy0, done0, cnt0, sum0, max0}, 0);
        chk("abort_out2", {bus2.a_o, bus2.b_o, busy2, done2, cnt2, sum2, max2}, 0);
        @(negedge clk);
        chk("abort_hold0", {bus0.a_o, bus0.b_o, busy0, done0, cnt0, sum0, max0}, 0);
        rst_n = 1'b1;
        mode = 0;
        @(negedge clk);
        sweep(1'b0);
        check_run("post_reset", 256, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
